// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the requester, result and SRAM pin signals of sram_arbiter.
//   vid_*  : video read request (req/addr in), ack/valid/data out
//   cpu_*  : CPU request (req/we/addr/wdata in), rdata/done/wait out
//   up_*   : ULAplus request (req/we/addr/wdata in), rdata/done out
//   sram_* : SRAM address/data/strobes out, sram_din in
// Modports: master = requesters plus the SRAM data pins; slave = the arbiter.
interface sram_arbiter_if;
    logic        vid_req;
    logic [18:0] vid_addr;
    logic        vid_ack;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_done;
    logic        cpu_wait;
    logic        up_req;
    logic        up_we;
    logic [18:0] up_addr;
    logic [7:0]  up_wdata;
    logic [7:0]  up_rdata;
    logic        up_done;
    logic [18:0] sram_a;
    logic [7:0]  sram_dout;
    logic        sram_oe;
    logic [7:0]  sram_din;
    logic        sram_n_rd;
    logic        sram_n_wr;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               up_req, up_we, up_addr, up_wdata, sram_din,
        input  vid_ack, vid_valid, vid_data, cpu_rdata, cpu_done, cpu_wait,
               up_rdata, up_done, sram_a, sram_dout, sram_oe, sram_n_rd, sram_n_wr
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               up_req, up_we, up_addr, up_wdata, sram_din,
        output vid_ack, vid_valid, vid_data, cpu_rdata, cpu_done, cpu_wait,
               up_rdata, up_done, sram_a, sram_dout, sram_oe, sram_n_rd, sram_n_wr
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit video SRAM port between video fetch, CPU and ULAplus.
// Ports:
//   clk28 : 28 MHz system clock
//   rst_n : asynchronous reset, active low
//   bus   : sram_arbiter_if.slave (requests in, results out, SRAM pins)
// Parameters: ACC_CYCLES (read strobe length / write pulse + 1, >=2),
//             MAX_WAIT (ungranted cycles before a CPU/UP request outranks video).
// Define SRAM_ARB_WRBUF_EN to add a one-entry CPU write-post buffer.
module sram_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int MAX_WAIT   = 12
) (
    input logic          clk28,
    input logic          rst_n,
    sram_arbiter_if.slave bus
);
`ifdef SRAM_ARB_WRBUF_EN
    localparam bit WRBUF = 1'b1;
`else
    localparam bit WRBUF = 1'b0;
`endif
    localparam int CW = $clog2(ACC_CYCLES + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_UP} grant_t;

    state_t      st;
    grant_t      own;
    grant_t      gnt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] cpu_age;
    logic [AW-1:0] up_age;
    logic        cpu_act;
    logic        up_act;
    logic        own_buf;
    logic        buf_full;
    logic [18:0] buf_addr;
    logic [7:0]  buf_data;
    logic        arb;
    logic        fin;
    logic        fin_cpu;
    logic        vid_pend;
    logic        up_pend;
    logic        cpu_direct;
    logic        cpu_src;
    logic        cpu_pro;
    logic        up_pro;
    logic        buf_take;
    logic        g_we;
    logic [18:0] g_addr;
    logic [7:0]  g_data;

    always_comb begin
        arb        = st == IDLE || (st == RD && cnt == '0) || st == WR_HOLD;
        fin        = arb && st != IDLE;
        fin_cpu    = fin && own == G_CPU && !own_buf;
        // A requester is excluded while being served and in its own done cycle.
        vid_pend   = bus.vid_req && !bus.vid_ack;
        up_pend    = bus.up_req && !bus.up_done && !up_act;
        cpu_direct = bus.cpu_req && !bus.cpu_done && !cpu_act && !buf_full && !(WRBUF && bus.cpu_we);
        buf_take   = WRBUF && bus.cpu_req && bus.cpu_we && !bus.cpu_done && !buf_full && !cpu_act;
        // A posted write competes at CPU priority in place of the CPU itself.
        cpu_src    = buf_full || cpu_direct;
        cpu_pro    = cpu_src && cpu_age == AW'(MAX_WAIT);
        up_pro     = up_pend && up_age == AW'(MAX_WAIT);
        gnt        = !arb ? G_NONE : cpu_pro ? G_CPU : up_pro ? G_UP : vid_pend ? G_VID :
                     cpu_src ? G_CPU : up_pend ? G_UP : G_NONE;
        g_we       = gnt == G_CPU ? (buf_full || bus.cpu_we) : (gnt == G_UP && bus.up_we);
        g_addr     = gnt == G_VID ? bus.vid_addr : gnt == G_UP ? bus.up_addr :
                     buf_full ? buf_addr : bus.cpu_addr;
        g_data     = gnt == G_UP ? bus.up_wdata : buf_full ? buf_data : bus.cpu_wdata;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            own           <= G_NONE;
            own_buf       <= 1'b0;
            cnt           <= '0;
            cpu_age       <= '0;
            up_age        <= '0;
            cpu_act       <= 1'b0;
            up_act        <= 1'b0;
            buf_full      <= 1'b0;
            buf_addr      <= '0;
            buf_data      <= '0;
            bus.vid_ack   <= 1'b0;
            bus.vid_valid <= 1'b0;
            bus.vid_data  <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_done  <= 1'b0;
            bus.cpu_wait  <= 1'b0;
            bus.up_rdata  <= '0;
            bus.up_done   <= 1'b0;
            bus.sram_a    <= '0;
            bus.sram_dout <= '0;
            bus.sram_oe   <= 1'b0;
            bus.sram_n_rd <= 1'b1;
            bus.sram_n_wr <= 1'b1;
        end else begin
            bus.vid_ack   <= gnt == G_VID;
            bus.vid_valid <= fin && st == RD && own == G_VID;
            bus.cpu_done  <= buf_take || fin_cpu;
            bus.up_done   <= fin && own == G_UP;
            bus.cpu_wait  <= bus.cpu_req && !bus.cpu_done && !fin_cpu && !buf_take;
            cpu_age <= gnt == G_CPU ? '0 : (cpu_src && !cpu_pro) ? cpu_age + 1'b1 : cpu_age;
            up_age  <= gnt == G_UP ? '0 : (up_pend && !up_pro) ? up_age + 1'b1 : up_age;
            if (buf_take) begin
                buf_full <= 1'b1;
                buf_addr <= bus.cpu_addr;
                buf_data <= bus.cpu_wdata;
            end
            case (st)
                RD: if (cnt != '0) cnt <= cnt - 1'b1;
                WR_SETUP: begin
                    st            <= WR_PULSE;
                    bus.sram_n_wr <= 1'b0;
                    cnt           <= CW'(ACC_CYCLES - 2);
                end
                WR_PULSE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        st            <= WR_HOLD;
                        bus.sram_n_wr <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (fin && st == RD && own == G_VID) bus.vid_data <= bus.sram_din;
            if (fin && st == RD && own == G_CPU) bus.cpu_rdata <= bus.sram_din;
            if (fin && st == RD && own == G_UP) bus.up_rdata <= bus.sram_din;
            if (fin) begin
                cpu_act <= 1'b0;
                up_act  <= 1'b0;
            end
            if (arb) begin
                own     <= gnt;
                own_buf <= gnt == G_CPU && buf_full;
                if (gnt == G_CPU) cpu_act <= !buf_full;
                if (gnt == G_CPU && buf_full) buf_full <= 1'b0;
                if (gnt == G_UP) up_act <= 1'b1;
                if (gnt == G_NONE) begin
                    st            <= IDLE;
                    bus.sram_n_rd <= 1'b1;
                    bus.sram_oe   <= 1'b0;
                end else begin
                    // n_rd and oe switch at the same edge, so they never overlap.
                    st            <= g_we ? WR_SETUP : RD;
                    bus.sram_a    <= g_addr;
                    bus.sram_n_rd <= g_we;
                    bus.sram_oe   <= g_we;
                    bus.sram_dout <= g_we ? g_data : bus.sram_dout;
                    cnt           <= CW'(ACC_CYCLES - 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter (default build, ACC_CYCLES=2, MAX_WAIT=12).
module tb_sram_arbiter;
    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   acks;
    int   dones;

    sram_arbiter_if bus();

    sram_arbiter dut (.clk28(clk28), .rst_n(rst_n), .bus(bus));

    always #5 clk28 = ~clk28;

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.up_req = 0; bus.up_we = 0; bus.up_addr = '0; bus.up_wdata = '0;
        bus.sram_din = '0;
        tick();
        tick();
        chk("rst_strobes", {31'd0, bus.sram_n_rd & bus.sram_n_wr}, 1);
        chk("rst_oe", {31'd0, bus.sram_oe}, 0);
        chk("rst_addr", {13'd0, bus.sram_a}, 0);
        chk("rst_data", {8'd0, bus.vid_data, bus.cpu_rdata, bus.up_rdata}, 0);
        chk("rst_pulses", {27'd0, bus.vid_ack, bus.vid_valid, bus.cpu_done, bus.up_done, bus.cpu_wait}, 0);
        rst_n = 1;
        // 1: idle after reset
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle", {24'd0, bus.sram_n_rd, bus.sram_n_wr, bus.sram_oe, bus.vid_ack,
                         bus.vid_valid, bus.cpu_done, bus.up_done, bus.cpu_wait}, 32'hC0);
        end
        // 2: video read
        bus.vid_req = 1; bus.vid_addr = 19'h01800; bus.sram_din = 8'h5A;
        tick();
        chk("vid_ack_c1", {31'd0, bus.vid_ack}, 1);
        chk("vid_nrd_c1", {31'd0, bus.sram_n_rd}, 0);
        chk("vid_addr_c1", {13'd0, bus.sram_a}, 32'h01800);
        bus.vid_req = 0;
        tick();
        chk("vid_c2", {29'd0, bus.vid_ack, bus.sram_n_rd, bus.vid_valid}, 0);
        tick();
        chk("vid_valid_c3", {31'd0, bus.vid_valid}, 1);
        chk("vid_data_c3", {24'd0, bus.vid_data}, 32'h5A);
        chk("vid_nrd_c3", {31'd0, bus.sram_n_rd}, 1);
        tick();
        chk("vid_valid_c4", {31'd0, bus.vid_valid}, 0);
        chk("vid_data_held", {24'd0, bus.vid_data}, 32'h5A);
        // 3: CPU write
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 19'h12345; bus.cpu_wdata = 8'hA5;
        tick();
        chk("cw_setup", {29'd0, bus.sram_oe, bus.sram_n_wr, bus.sram_n_rd}, 3'b111);
        chk("cw_addr", {13'd0, bus.sram_a}, 32'h12345);
        chk("cw_dout", {24'd0, bus.sram_dout}, 32'hA5);
        chk("cw_wait", {31'd0, bus.cpu_wait}, 1);
        tick();
        chk("cw_pulse", {30'd0, bus.sram_oe, bus.sram_n_wr}, 2'b10);
        tick();
        chk("cw_hold", {29'd0, bus.sram_oe, bus.sram_n_wr, bus.cpu_done}, 3'b110);
        chk("cw_hold_dout", {24'd0, bus.sram_dout}, 32'hA5);
        tick();
        chk("cw_done", {29'd0, bus.cpu_done, bus.sram_oe, bus.cpu_wait}, 3'b100);
        bus.cpu_req = 0; bus.cpu_we = 0;
        tick();
        chk("cw_after", {30'd0, bus.cpu_done, bus.sram_oe}, 0);
        // UP write at the top address
        bus.up_req = 1; bus.up_we = 1; bus.up_addr = 19'h7FFFF; bus.up_wdata = 8'hC3;
        tick();
        chk("uw_setup", {13'd0, bus.sram_a}, 32'h7FFFF);
        chk("uw_dout", {24'd0, bus.sram_dout}, 32'hC3);
        tick();
        chk("uw_pulse", {31'd0, bus.sram_n_wr}, 0);
        tick();
        chk("uw_hold", {30'd0, bus.sram_oe, bus.sram_n_wr}, 2'b11);
        tick();
        chk("uw_done", {30'd0, bus.up_done, bus.sram_oe}, 2'b10);
        bus.up_req = 0; bus.up_we = 0;
        tick();
        // 5: CPU and UP reads in the same cycle
        bus.sram_din = 8'h11;
        bus.cpu_req = 1; bus.cpu_addr = 19'h00AAA;
        bus.up_req = 1; bus.up_addr = 19'h00BBB;
        tick();
        chk("cu_first", {13'd0, bus.sram_a}, 32'h00AAA);
        chk("cu_nrd1", {31'd0, bus.sram_n_rd}, 0);
        tick();
        tick();
        chk("cu_cpu_done", {31'd0, bus.cpu_done}, 1);
        chk("cu_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'h11);
        chk("cu_up_addr", {13'd0, bus.sram_a}, 32'h00BBB);
        chk("cu_up_nrd", {30'd0, bus.sram_n_rd, bus.up_done}, 0);
        bus.cpu_req = 0; bus.sram_din = 8'h22;
        tick();
        tick();
        chk("cu_up_done", {31'd0, bus.up_done}, 1);
        chk("cu_up_rdata", {24'd0, bus.up_rdata}, 32'h22);
        chk("cu_idle", {31'd0, bus.sram_n_rd}, 1);
        bus.up_req = 0;
        tick();
        // 4: video hogging vs aging CPU read
        bus.vid_req = 1; bus.vid_addr = 19'h00100;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 19'h00ABC; bus.sram_din = 8'h3C;
        acks = 0;
        dones = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            acks += int'(bus.vid_ack);
            dones += int'(bus.cpu_done);
            if (i == 1 || i == 14) chk("age_wait", {31'd0, bus.cpu_wait}, 1);
            if (i == 13) chk("age_addr", {13'd0, bus.sram_a}, 32'h00ABC);
            if (i == 13) chk("age_nrd", {31'd0, bus.sram_n_rd}, 0);
        end
        chk("age_vid_acks", acks, 6);
        chk("age_no_early_done", dones, 0);
        tick();
        chk("age_done", {31'd0, bus.cpu_done}, 1);
        chk("age_rdata", {24'd0, bus.cpu_rdata}, 32'h3C);
        chk("age_wait_clr", {31'd0, bus.cpu_wait}, 0);
        chk("age_vid_regrant", {31'd0, bus.vid_ack}, 1);
        bus.cpu_req = 0; bus.vid_req = 0;
        repeat (4) tick();
        // 6: reset in the middle of a write pulse
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 19'h00055; bus.cpu_wdata = 8'h77;
        tick();
        tick();
        chk("rw_pulse", {31'd0, bus.sram_n_wr}, 0);
        rst_n = 0;
        #1;
        chk("rw_abort", {28'd0, bus.sram_n_wr, bus.sram_oe, bus.sram_n_rd, bus.cpu_wait}, 4'b1010);
        chk("rw_addr", {13'd0, bus.sram_a}, 0);
        bus.cpu_req = 0; bus.cpu_we = 0;
        tick();
        tick();
        rst_n = 1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dones += int'(bus.cpu_done);
        end
        chk("rw_no_done", dones, 0);
        chk("rw_idle", {29'd0, bus.sram_n_wr, bus.sram_oe, bus.sram_n_rd}, 3'b101);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
